uart_rx_tp_decoder: RTL and testbench
=====================================

Name: uart_rx_tp_decoder

Overview:
UART receiver plus ASCII line parser, the receive-side counterpart of the sensor UART transmitter.
- Deserialises 8N1 bytes from `uart_rx` and parses lines of the form `T=<dec>,P=<dec>\n`.
- Presents the two 16-bit values, updated atomically, for the HDMI text renderer's `t_value`/`p_value` inputs.
- Sits in the 25 MHz `clk` domain; the top level retimes its outputs into the pixel domain.

Parameters:
- CLK_HZ, 25000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer division; must be >= 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- uart_rx  input  1  asynchronous serial input, idle high.
- t_value  output  16  last accepted T value.
- p_value  output  16  last accepted P value.
- values_valid  output  1  one-cycle pulse when t_value/p_value update.
- byte_data  output  8  last received byte.
- byte_valid  output  1  one-cycle pulse, byte_data valid.
- frame_err  output  1  one-cycle pulse on bad stop bit (or parity, if enabled).
- parse_err  output  1  one-cycle pulse on line syntax error.

Behaviour:
Reset (rst_n low at a posedge), applied in any state, including mid-byte or mid-line:
- t_value=0, p_value=0, byte_data=0; all pulses 0.
- RX FSM to IDLE, parser to WAIT_T, accumulator cleared.
- Synchroniser flops set to 1.

Input synchroniser:
- 2-FF synchroniser on uart_rx; all RX logic uses the synchronised signal (rx_s).

RX FSM, bit counter 0..CLKS_PER_BIT-1:
- IDLE: rx_s==0 -> START, counter cleared.
- START: at count CLKS_PER_BIT/2 - 1, sample rx_s.
  - 1 -> IDLE (glitch, no error pulse).
  - 0 -> DATA, counter cleared.
- DATA: sample at count CLKS_PER_BIT-1, mid-bit. LSB first, 8 bits, then STOP.
- STOP: sample at mid-bit.
  - 1: byte_valid=1 and byte_data updated on the same cycle, then IDLE.
  - 0: frame_err=1, byte discarded (byte_data unchanged), go to BREAK.
- BREAK: wait for rx_s==1, then IDLE.
- Byte latency: byte_valid asserts 2 (sync) + 9.5·CLKS_PER_BIT (±1) cycles after the start-bit falling edge at the pin.

Parser, advances only on byte_valid:
- WAIT_T: 'T' -> T_EQ. Any other byte is ignored, with no error.
- T_EQ: '=' -> T_NUM with acc=0, ndig=0. Else error.
- T_NUM:
  - '0'..'9' -> acc = acc*10 + digit, ndig++.
  - ',' with ndig>=1 -> latch t_tmp=acc -> P_CH.
  - Else error.
- P_CH: 'P' -> P_EQ. Else error.
- P_EQ: '=' -> P_NUM with acc=0, ndig=0. Else error.
- P_NUM:
  - Digits as in T_NUM.
  - '\r' is ignored.
  - '\n' with ndig>=1: t_value<=t_tmp and p_value<=acc on the same edge, values_valid=1 that cycle, -> WAIT_T.
  - Else error.
- Accumulator width and limits:
  - Accumulator is 17 bits.
  - If acc*10+digit > 65535, acc saturates to 65535 and stays there.
  - A 6th digit is an error.
- Error: parse_err=1 for one cycle, go to SKIP.
  - SKIP: '\n' -> WAIT_T; every other byte is ignored.
  - t_value/p_value keep their previous values; a partial line is never committed.
- frame_err does not affect parser state; the discarded byte simply never arrives.

Optional Feature:
UART_RX_PARITY_EN
- Defined: frame is 8E1. The bit after D7 is even parity, sampled mid-bit before STOP. Mismatch -> frame_err pulse at STOP time, byte discarded, no byte_valid.
- Undefined: 8N1 as above. No parity state or logic is synthesised.

Test Plan:
Bench uses CLK_HZ=1000000 and BAUD=100000 (10 clocks/bit).
1. Reset mid-byte: rst_n=0 during the DATA bits of 0x55 -> all outputs 0; the next byte 0x41 is received cleanly with byte_data=0x41 and one byte_valid.
2. Valid line: send "T=1234,P=5678\r\n" -> one values_valid pulse with t_value=1234, p_value=5678; byte_valid pulses 15 times; no errors.
3. Saturation and length: "T=70000,P=65535\n" -> t_value=65535, p_value=65535. Then "T=123456,P=1\n" -> parse_err on the '6'; values stay 65535/65535.
4. Syntax recovery: "T=,P=9\nT=7,P=8\n" -> parse_err on the ','; the first line is discarded; the second gives t_value=7, p_value=8.
5. Framing: send 0x54 with stop bit 0, held low for 20 bit times, then "T=1,P=2\n" -> one frame_err, no byte_valid for the bad frame, then t_value=1, p_value=2.
6. Glitch rejection: 3-clock low pulse on uart_rx -> no byte_valid and no frame_err. With UART_RX_PARITY_EN defined, 0x31 sent with a wrong parity bit -> frame_err and no byte_valid.

Source files
------------

// File: rtl/uart_rx_tp_decoder.sv
// rtl/uart_rx_tp_decoder.sv - UART receiver and "T=<dec>,P=<dec>\n" line parser; optional macro UART_RX_PARITY_EN selects 8E1 framing
module uart_rx_tp_decoder #(
    parameter int CLK_HZ = 25000000,
    parameter int BAUD   = 9600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [15:0] t_value,
    output logic [15:0] p_value,
    output logic        values_valid,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        frame_err,
    output logic        parse_err
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic rx_m, rx_s;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
    logic par_bad, par_bad_next;
`else
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
`endif

    rx_state_t rx_state, rx_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0] bit_idx, bit_next;
    logic [7:0] shreg, sh_next, bdata_next;
    logic bvalid_next, ferr_next;

    // Receiver state, bit timer, shift register and byte outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
`endif
        end else begin
            rx_state   <= rx_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_next;
            shreg      <= sh_next;
            byte_data  <= bdata_next;
            byte_valid <= bvalid_next;
            frame_err  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_next;
`endif
        end
    end

    // Receiver next state: start bit checked at half period, then one sample per bit period
    always_comb begin
        rx_next     = rx_state;
        cnt_next    = cnt + 1'b1;
        bit_next    = bit_idx;
        sh_next     = shreg;
        bdata_next  = byte_data;
        bvalid_next = 1'b0;
        ferr_next   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad;
`endif
        case (rx_state)
            RX_IDLE: begin
                cnt_next = '0;
                if (!rx_s) rx_next = RX_START;
            end
            RX_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_next = '0;
                    bit_next = '0;
                    rx_next  = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_next = '0;
                    sh_next  = {rx_s, shreg[7:1]};
                    bit_next = bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) rx_next = RX_PARITY;
`else
                    if (bit_idx == 3'd7) rx_next = RX_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (cnt == CNT_FULL) begin
                    cnt_next     = '0;
                    par_bad_next = rx_s ^ (^shreg);
                    rx_next      = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        ferr_next = 1'b1;
                        rx_next   = RX_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        ferr_next = 1'b1;
                        rx_next   = RX_IDLE;
`endif
                    end else begin
                        bvalid_next = 1'b1;
                        bdata_next  = shreg;
                        rx_next     = RX_IDLE;
                    end
                end
            end
            RX_BREAK: begin
                cnt_next = '0;
                if (rx_s) rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    typedef enum logic [2:0] {P_WAIT_T, P_T_EQ, P_T_NUM, P_P_CH, P_P_EQ, P_P_NUM, P_SKIP} ps_t;

    ps_t ps, ps_next;
    logic [16:0] acc, acc_next, acc_digit;
    logic [20:0] acc_sum;
    logic [2:0] ndig, ndig_next;
    logic [15:0] t_tmp, t_tmp_next, t_next, p_next;
    logic vv_next, perr_next, is_digit, err;

    // Parser state, accumulator and committed values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps           <= P_WAIT_T;
            acc          <= '0;
            ndig         <= '0;
            t_tmp        <= '0;
            t_value      <= '0;
            p_value      <= '0;
            values_valid <= 1'b0;
            parse_err    <= 1'b0;
        end else begin
            ps           <= ps_next;
            acc          <= acc_next;
            ndig         <= ndig_next;
            t_tmp        <= t_tmp_next;
            t_value      <= t_next;
            p_value      <= p_next;
            values_valid <= vv_next;
            parse_err    <= perr_next;
        end
    end

    // Parser next state: advances once per received byte; any syntax error skips to end of line
    always_comb begin
        ps_next    = ps;
        acc_next   = acc;
        ndig_next  = ndig;
        t_tmp_next = t_tmp;
        t_next     = t_value;
        p_next     = p_value;
        vv_next    = 1'b0;
        perr_next  = 1'b0;
        err        = 1'b0;
        is_digit   = (byte_data >= 8'h30) && (byte_data <= 8'h39);
        acc_sum    = 21'(acc) * 21'd10 + 21'(byte_data - 8'h30);
        acc_digit  = (acc_sum > 21'd65535) ? 17'd65535 : acc_sum[16:0];
        if (byte_valid) begin
            case (ps)
                P_WAIT_T: if (byte_data == 8'h54) ps_next = P_T_EQ;
                P_T_EQ, P_P_EQ: begin
                    if (byte_data == 8'h3D) begin
                        acc_next  = '0;
                        ndig_next = '0;
                        ps_next   = (ps == P_T_EQ) ? P_T_NUM : P_P_NUM;
                    end else err = 1'b1;
                end
                P_P_CH: begin
                    if (byte_data == 8'h50) ps_next = P_P_EQ;
                    else err = 1'b1;
                end
                P_T_NUM, P_P_NUM: begin
                    if (is_digit && ndig != 3'd5) begin
                        acc_next  = acc_digit;
                        ndig_next = ndig + 1'b1;
                    end else if (ps == P_T_NUM && byte_data == 8'h2C && ndig != 3'd0) begin
                        t_tmp_next = acc[15:0];
                        ps_next    = P_P_CH;
                    end else if (ps == P_P_NUM && byte_data == 8'h0D) begin
                        ps_next = P_P_NUM;
                    end else if (ps == P_P_NUM && byte_data == 8'h0A && ndig != 3'd0) begin
                        t_next  = t_tmp;
                        p_next  = acc[15:0];
                        vv_next = 1'b1;
                        ps_next = P_WAIT_T;
                    end else err = 1'b1;
                end
                P_SKIP: if (byte_data == 8'h0A) ps_next = P_WAIT_T;
                default: ps_next = P_WAIT_T;
            endcase
            if (err) begin
                perr_next = 1'b1;
                ps_next   = P_SKIP;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_tp_decoder.sv
// tb/tb_uart_rx_tp_decoder.sv - directed self-checking bench for uart_rx_tp_decoder
module tb_uart_rx_tp_decoder;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rx = 1'b1;
    logic [15:0] t_value, p_value;
    logic values_valid, byte_valid, frame_err, parse_err;
    logic [7:0] byte_data;

    int n_tests = 0;
    int n_fail = 0;
    int n_byte = 0;
    int n_vv = 0;
    int n_ferr = 0;
    int n_perr = 0;
    logic [7:0] perr_byte = 8'h00;

    uart_rx_tp_decoder #(.CLK_HZ(1000000), .BAUD(100000)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .t_value(t_value), .p_value(p_value), .values_valid(values_valid),
        .byte_data(byte_data), .byte_valid(byte_valid),
        .frame_err(frame_err), .parse_err(parse_err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid) n_byte <= n_byte + 1;
            if (values_valid) n_vv <= n_vv + 1;
            if (frame_err) n_ferr <= n_ferr + 1;
            if (parse_err) begin
                n_perr <= n_perr + 1;
                perr_byte <= byte_data;
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = ^b;
        repeat (CPB) @(negedge clk);
`endif
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic test_reset;
        int b0, f0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (t_value !== 16'd0) begin n_fail++; $display("FAIL reset_t: got %0d expected 0", t_value); end
        n_tests++; if (p_value !== 16'd0) begin n_fail++; $display("FAIL reset_p: got %0d expected 0", p_value); end
        n_tests++; if (byte_data !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h expected 00", byte_data); end
        n_tests++; if ({byte_valid, values_valid, frame_err, parse_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {byte_valid, values_valid, frame_err, parse_err}); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        b0 = n_byte;
        f0 = n_ferr;
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if ({t_value, p_value, byte_data} !== 40'd0) begin n_fail++; $display("FAIL reset_midbyte_outputs: got %h expected 0", {t_value, p_value, byte_data}); end
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_frame(8'h41, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        n_tests++; if (n_byte - b0 !== 1) begin n_fail++; $display("FAIL reset_next_count: got %0d expected 1", n_byte - b0); end
        n_tests++; if (byte_data !== 8'h41) begin n_fail++; $display("FAIL reset_next_byte: got %h expected 41", byte_data); end
        n_tests++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL reset_next_ferr: got %0d expected 0", n_ferr - f0); end
    endtask

    task automatic test_valid_line;
        int b0 = n_byte, v0 = n_vv, f0 = n_ferr, p0 = n_perr;
        send_str("T=1234,P=5678\r\n");
        n_tests++; if (n_vv - v0 !== 1) begin n_fail++; $display("FAIL valid_vv: got %0d expected 1", n_vv - v0); end
        n_tests++; if (t_value !== 16'd1234) begin n_fail++; $display("FAIL valid_t: got %0d expected 1234", t_value); end
        n_tests++; if (p_value !== 16'd5678) begin n_fail++; $display("FAIL valid_p: got %0d expected 5678", p_value); end
        n_tests++; if (n_byte - b0 !== 15) begin n_fail++; $display("FAIL valid_bytes: got %0d expected 15", n_byte - b0); end
        n_tests++; if (byte_data !== 8'h0A) begin n_fail++; $display("FAIL valid_last_byte: got %h expected 0a", byte_data); end
        n_tests++; if ((n_ferr - f0) + (n_perr - p0) !== 0) begin n_fail++; $display("FAIL valid_errors: got %0d expected 0", (n_ferr - f0) + (n_perr - p0)); end
    endtask

    task automatic test_saturation;
        int v0 = n_vv, p0 = n_perr;
        send_str("T=70000,P=65535\n");
        n_tests++; if (t_value !== 16'd65535) begin n_fail++; $display("FAIL sat_t: got %0d expected 65535", t_value); end
        n_tests++; if (p_value !== 16'd65535) begin n_fail++; $display("FAIL sat_p: got %0d expected 65535", p_value); end
        n_tests++; if (n_vv - v0 !== 1 || n_perr - p0 !== 0) begin n_fail++; $display("FAIL sat_pulses: got vv=%0d perr=%0d expected vv=1 perr=0", n_vv - v0, n_perr - p0); end
        v0 = n_vv;
        p0 = n_perr;
        send_str("T=123456,P=1\n");
        n_tests++; if (n_perr - p0 !== 1) begin n_fail++; $display("FAIL len_perr: got %0d expected 1", n_perr - p0); end
        n_tests++; if (perr_byte !== 8'h36) begin n_fail++; $display("FAIL len_perr_byte: got %h expected 36", perr_byte); end
        n_tests++; if (n_vv - v0 !== 0) begin n_fail++; $display("FAIL len_vv: got %0d expected 0", n_vv - v0); end
        n_tests++; if ({t_value, p_value} !== {16'd65535, 16'd65535}) begin n_fail++; $display("FAIL len_values: got %0d/%0d expected 65535/65535", t_value, p_value); end
    endtask

    task automatic test_syntax_recovery;
        int v0 = n_vv, p0 = n_perr;
        send_str("T=,P=9\nT=7,P=8\n");
        n_tests++; if (n_perr - p0 !== 1) begin n_fail++; $display("FAIL syn_perr: got %0d expected 1", n_perr - p0); end
        n_tests++; if (perr_byte !== 8'h2C) begin n_fail++; $display("FAIL syn_perr_byte: got %h expected 2c", perr_byte); end
        n_tests++; if (n_vv - v0 !== 1) begin n_fail++; $display("FAIL syn_vv: got %0d expected 1", n_vv - v0); end
        n_tests++; if ({t_value, p_value} !== {16'd7, 16'd8}) begin n_fail++; $display("FAIL syn_values: got %0d/%0d expected 7/8", t_value, p_value); end
    endtask

    task automatic test_framing;
        int b0 = n_byte, f0 = n_ferr, p0 = n_perr;
        send_frame(8'h54, 1'b0);
        uart_rx = 1'b0;
        repeat (19 * CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        n_tests++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL frame_ferr: got %0d expected 1", n_ferr - f0); end
        n_tests++; if (n_byte - b0 !== 0) begin n_fail++; $display("FAIL frame_nobyte: got %0d expected 0", n_byte - b0); end
        send_str("T=1,P=2\n");
        n_tests++; if ({t_value, p_value} !== {16'd1, 16'd2}) begin n_fail++; $display("FAIL frame_values: got %0d/%0d expected 1/2", t_value, p_value); end
        n_tests++; if (n_byte - b0 !== 8 || n_perr - p0 !== 0) begin n_fail++; $display("FAIL frame_line: got bytes=%0d perr=%0d expected bytes=8 perr=0", n_byte - b0, n_perr - p0); end
    endtask

    task automatic test_glitch;
        int b0 = n_byte, f0 = n_ferr;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        n_tests++; if (n_byte - b0 !== 0) begin n_fail++; $display("FAIL glitch_byte: got %0d expected 0", n_byte - b0); end
        n_tests++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected 0", n_ferr - f0); end
`ifdef UART_RX_PARITY_EN
        b0 = n_byte;
        f0 = n_ferr;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = (8'h31 >> i) & 1;
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        n_tests++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL parity_ferr: got %0d expected 1", n_ferr - f0); end
        n_tests++; if (n_byte - b0 !== 0) begin n_fail++; $display("FAIL parity_nobyte: got %0d expected 0", n_byte - b0); end
`endif
    endtask

    initial begin
        test_reset;
        test_valid_line;
        test_saturation;
        test_syntax_recovery;
        test_framing;
        test_glitch;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
